// File: rtl/branch_issue_sched.sv
`default_nettype none
// ============================================================================
// Module      : branch_issue_sched
// Description : Age-ordered collapsing issue queue for the branch pipe; issues
//               the oldest ready, non-killed op each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_issue_sched #(
  parameter int CNTRL_SIZE = 7,
  parameter int NCOMMIT    = 32,
  parameter int LNCOMMIT   = 5,
  parameter int NENT       = 8,
  parameter int LNENT      = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LNCOMMIT-1:0]   in_rd,
  input  logic [CNTRL_SIZE-1:0] in_control,
  input  logic                  in_makes_rd,
  input  logic                  in_dep1_valid,
  input  logic                  in_dep2_valid,
  input  logic [LNCOMMIT-1:0]   in_dep1,
  input  logic [LNCOMMIT-1:0]   in_dep2,
  input  logic [NCOMMIT-1:0]    src_ready,
  input  logic [NCOMMIT-1:0]    commit_kill,
  output logic                  br_enable,
  output logic [LNCOMMIT-1:0]   br_rd,
  output logic [CNTRL_SIZE-1:0] br_control,
  output logic                  br_makes_rd,
  output logic [LNENT:0]        count
);

  localparam logic [LNENT:0] c_full = (LNENT+1)'(NENT);
  localparam logic [LNENT:0] c_one  = (LNENT+1)'(1);

  typedef struct packed {
    logic                  valid;
    logic [LNCOMMIT-1:0]   rd;
    logic [CNTRL_SIZE-1:0] control;
    logic                  makes_rd;
    logic                  rdy1;
    logic                  rdy2;
    logic [LNCOMMIT-1:0]   dep1;
    logic [LNCOMMIT-1:0]   dep2;
  } entry_t;

  entry_t                r_q [NENT];
  entry_t                w_q_nxt [NENT];
  entry_t                w_new;
  entry_t                w_sel_ent;
  logic [LNENT:0]        r_count;
  logic [LNENT:0]        w_pos;
  logic [LNENT:0]        w_count_nxt;
  logic [NENT-1:0]       w_elig;
  logic [NENT-1:0]       w_sel;
  logic [NENT-1:0]       w_keep;
  logic                  w_any_sel;
  logic                  w_accept;
  logic                  w_new_live;
  logic                  r_br_enable;
  logic [LNCOMMIT-1:0]   r_br_rd;
  logic [CNTRL_SIZE-1:0] r_br_control;
  logic                  r_br_makes_rd;

  assign in_ready    = (r_count != c_full);
  assign count       = r_count;
  assign br_enable   = r_br_enable;
  assign br_rd       = r_br_rd;
  assign br_control  = r_br_control;
  assign br_makes_rd = r_br_makes_rd;

  assign w_accept   = in_valid & in_ready;
  assign w_new_live = w_accept & ~commit_kill[in_rd];

  // Readiness uses the live src_ready so a wakeup counts in the same cycle.
  always_comb begin
    w_elig = '0;
    w_keep = '0;
    for (int i = 0; i < NENT; i++) begin
      w_elig[i] = r_q[i].valid & ~commit_kill[r_q[i].rd]
                & (r_q[i].rdy1 | src_ready[r_q[i].dep1])
                & (r_q[i].rdy2 | src_ready[r_q[i].dep2]);
      w_keep[i] = r_q[i].valid & ~commit_kill[r_q[i].rd];
    end
  end

  // Isolating the lowest set bit gives the oldest eligible entry.
  assign w_sel     = w_elig & (~w_elig + {{(NENT-1){1'b0}}, 1'b1});
  assign w_any_sel = |w_elig;

  always_comb begin
    w_sel_ent = '0;
    for (int i = 0; i < NENT; i++) begin
      if (w_sel[i]) w_sel_ent = r_q[i];
    end
  end

  always_comb begin
    w_new          = '0;
    w_new.valid    = 1'b1;
    w_new.rd       = in_rd;
    w_new.control  = in_control;
    w_new.makes_rd = in_makes_rd;
    w_new.rdy1     = ~in_dep1_valid | src_ready[in_dep1];
    w_new.rdy2     = ~in_dep2_valid | src_ready[in_dep2];
    w_new.dep1     = in_dep1;
    w_new.dep2     = in_dep2;
  end

  // Survivors pack toward index 0 in age order; the new op goes right behind.
  always_comb begin
    for (int i = 0; i < NENT; i++) w_q_nxt[i] = '0;
    w_pos = '0;
    for (int i = 0; i < NENT; i++) begin
      if (w_keep[i] & ~w_sel[i]) begin
        w_q_nxt[w_pos[LNENT-1:0]]      = r_q[i];
        w_q_nxt[w_pos[LNENT-1:0]].rdy1 = r_q[i].rdy1 | src_ready[r_q[i].dep1];
        w_q_nxt[w_pos[LNENT-1:0]].rdy2 = r_q[i].rdy2 | src_ready[r_q[i].dep2];
        w_pos = w_pos + c_one;
      end
    end
    w_count_nxt = w_pos;
    if (w_new_live) begin
      w_q_nxt[w_pos[LNENT-1:0]] = w_new;
      w_count_nxt = w_pos + c_one;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NENT; i++) r_q[i] <= '0;
      r_count       <= '0;
      r_br_enable   <= 1'b0;
      r_br_rd       <= '0;
      r_br_control  <= '0;
      r_br_makes_rd <= 1'b0;
    end else begin
      for (int i = 0; i < NENT; i++) r_q[i] <= w_q_nxt[i];
      r_count     <= w_count_nxt;
      r_br_enable <= w_any_sel;
      if (w_any_sel) begin
        r_br_rd       <= w_sel_ent.rd;
        r_br_control  <= w_sel_ent.control;
        r_br_makes_rd <= w_sel_ent.makes_rd;
      end
    end
  end

endmodule
`default_nettype wire
